// File: rtl/sample_mixer_player_if.sv
// sample_mixer_player_if: control, ROM port and mix output bundle for the sample playback engine.
// Latency: none (wires only); rom_q is expected one cycle after rom_addr.
// Backpressure: none; all signals are level or single-cycle pulses.
interface sample_mixer_player_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 5,
    parameter int ADDR_W = 12,
    parameter int MIX_W  = 7
);
    logic [NUM_CH-1:0]        play;
    logic [NUM_CH-1:0]        stop;
    logic [NUM_CH-1:0]        loop;
    logic [NUM_CH*ADDR_W-1:0] start_addr;
    logic [NUM_CH*ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0]        rom_addr;
    logic [DATA_W-1:0]        rom_q;
    logic [MIX_W-1:0]         mix;
    logic                     mix_valid;
    logic [NUM_CH-1:0]        active;
    logic [NUM_CH-1:0]        done;

    // Controller side: owns the channel controls and the ROM data return.
    modport master (
        output play, stop, loop, start_addr, end_addr, rom_q,
        input  rom_addr, mix, mix_valid, active, done
    );

    // Engine side.
    modport slave (
        input  play, stop, loop, start_addr, end_addr, rom_q,
        output rom_addr, mix, mix_valid, active, done
    );
endinterface

// File: rtl/sample_mixer_player.sv
// sample_mixer_player: NUM_CH-channel ROM sample playback, one shared ROM port, summed mix output.
// Latency: channel j addressed at tick+1+j, data added at tick+2+j, mix/mix_valid at tick+NUM_CH+2.
// Backpressure: none; free-running sample period, mix is held and must be taken on each mix_valid.
module sample_mixer_player #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 5,
    parameter int ADDR_W   = 12,
    parameter int MIX_W    = 7,
    parameter int TICK_DIV = 2085
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    sample_mixer_player_if.slave bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;

    // Add stage: the slot addressed last cycle, whose ROM data is on rom_q now.
    logic                add_vld_q, add_vld_d;
    logic [IDX_W-1:0]    add_idx_q, add_idx_d;
    logic                add_act_q, add_act_d;

    logic [MIX_W-1:0]    acc_q, acc_d;
    logic [MIX_W-1:0]    mix_q, mix_d;
    logic                mix_valid_q, mix_valid_d;

    logic [NUM_CH-1:0]   active_q, active_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [NUM_CH-1:0]   play_prev_q, play_prev_d;
    logic [ADDR_W-1:0]   ptr_q [NUM_CH];
    logic [ADDR_W-1:0]   ptr_d [NUM_CH];

    logic                tick;
    logic [ADDR_W-1:0]   rom_addr_c;
    logic [MIX_W-1:0]    sample_c;
    logic [MIX_W-1:0]    sum_c;

    // Sample-period counter and the scan sequencer that walks one channel per cycle after each tick.
    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        add_vld_d  = 1'b0;
        add_idx_d  = scan_idx_q;
        add_act_d  = 1'b0;
        rom_addr_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end
            end
            ST_SCAN: begin
                // Active flag is captured here so a trigger in this same cycle cannot sneak in data.
                rom_addr_c = ptr_q[scan_idx_q];
                add_vld_d  = 1'b1;
                add_act_d  = active_q[scan_idx_q];
                if (scan_idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulate returning ROM data; the first slot of a scan restarts the sum, the last publishes it.
    always_comb begin
        sample_c    = add_act_q ? MIX_W'(bus.rom_q) : '0;
        sum_c       = ((add_idx_q == '0) ? '0 : acc_q) + sample_c;
        acc_d       = acc_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        if (add_vld_q) begin
            acc_d = sum_c;
            if (add_idx_q == IDX_LAST) begin
                mix_d       = sum_c;
                mix_valid_d = 1'b1;
            end
        end
    end

    // Per-channel control: stop beats trigger, trigger beats the scan-slot pointer advance.
    always_comb begin
        active_d    = active_q;
        done_d      = '0;
        play_prev_d = bus.play;
        for (int i = 0; i < NUM_CH; i++) begin
            ptr_d[i] = ptr_q[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.stop[i]) begin
                active_d[i] = 1'b0;
            end else if (bus.play[i] && !play_prev_q[i]) begin
                active_d[i] = 1'b1;
                ptr_d[i]    = bus.start_addr[i*ADDR_W +: ADDR_W];
            end else if ((state_q == ST_SCAN) && (scan_idx_q == IDX_W'(i)) && active_q[i]) begin
                // Region end is inclusive; start > end degenerates to a single sample.
                if (ptr_q[i] >= bus.end_addr[i*ADDR_W +: ADDR_W]) begin
                    if (bus.loop[i]) begin
                        ptr_d[i] = bus.start_addr[i*ADDR_W +: ADDR_W];
                    end else begin
                        active_d[i] = 1'b0;
                        done_d[i]   = 1'b1;
                    end
                end else begin
                    ptr_d[i] = ptr_q[i] + ADDR_W'(1);
                end
            end
        end
    end

    // State register; reset aborts any scan in flight and primes edge detect from the live play input.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            scan_idx_q  <= '0;
            add_vld_q   <= 1'b0;
            add_idx_q   <= '0;
            add_act_q   <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            active_q    <= '0;
            done_q      <= '0;
            play_prev_q <= bus.play;
            for (int i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scan_idx_q  <= scan_idx_d;
            add_vld_q   <= add_vld_d;
            add_idx_q   <= add_idx_d;
            add_act_q   <= add_act_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            active_q    <= active_d;
            done_q      <= done_d;
            play_prev_q <= play_prev_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign bus.rom_addr  = rom_addr_c;
    assign bus.mix       = mix_q;
    assign bus.mix_valid = mix_valid_q;
    assign bus.active    = active_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sample_mixer_player.sv
// tb_sample_mixer_player: directed scenarios plus random stimulus against a cycle-arithmetic model.
// Latency: model predicts every output every cycle from the sample-period schedule.
// Backpressure: none.
module tb_sample_mixer_player;
    localparam int NCH = 4;
    localparam int TD  = 16;
    localparam int AW  = 12;

    logic clk;
    logic reset;

    sample_mixer_player_if #(.NUM_CH(NCH), .DATA_W(5), .ADDR_W(AW), .MIX_W(7)) bus ();

    sample_mixer_player #(
        .NUM_CH(NCH), .DATA_W(5), .ADDR_W(AW), .MIX_W(7), .TICK_DIV(TD)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with ROM[a] = a[4:0].
    always_ff @(posedge clk) bus.rom_q <= bus.rom_addr[4:0];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    function automatic int rom(input int a);
        return a & 31;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit         armed = 1'b0;
    int         cyc;
    int         acc_sum;
    int         m_ptr [NCH];
    logic [3:0] m_active, m_done, m_play_d;
    logic       m_mv;
    int         m_mix;

    // Predict outputs from the sample-period schedule, compare, then step the model one cycle.
    always @(negedge clk) begin
        int         j, e_rom, st, en;
        bit         slot, trig;
        logic [3:0] n_act, n_done;
        int         n_ptr [NCH];
        slot  = (cyc >= TD) && ((cyc % TD) < NCH);
        j     = cyc % TD;
        e_rom = slot ? m_ptr[j] : 0;
        if (armed) begin
            chk("active",    bus.active,    m_active);
            chk("done",      bus.done,      m_done);
            chk("mix_valid", bus.mix_valid, m_mv);
            chk("mix",       bus.mix,       m_mix);
            chk("rom_addr",  bus.rom_addr,  e_rom);
        end
        if (reset) begin
            m_active = '0; m_done = '0; m_mv = 1'b0; m_mix = 0;
            m_play_d = bus.play; cyc = 0; acc_sum = 0;
            for (int i = 0; i < NCH; i++) m_ptr[i] = 0;
        end else begin
            n_act  = m_active;
            n_done = '0;
            for (int i = 0; i < NCH; i++) n_ptr[i] = m_ptr[i];
            if (slot) begin
                if (j == 0) acc_sum = 0;
                if (m_active[j]) acc_sum += rom(m_ptr[j]);
            end
            m_mv = 1'b0;
            if (cyc >= TD && (cyc % TD) == NCH) begin
                m_mix = acc_sum;
                m_mv  = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                st   = int'(bus.start_addr[i*AW +: AW]);
                en   = int'(bus.end_addr[i*AW +: AW]);
                trig = bus.play[i] && !m_play_d[i];
                if (bus.stop[i]) n_act[i] = 1'b0;
                else if (trig) begin
                    n_act[i] = 1'b1;
                    n_ptr[i] = st;
                end else if (slot && j == i && m_active[i]) begin
                    if (m_ptr[i] >= en) begin
                        if (bus.loop[i]) n_ptr[i] = st;
                        else begin
                            n_act[i]  = 1'b0;
                            n_done[i] = 1'b1;
                        end
                    end else n_ptr[i] = (m_ptr[i] + 1) & 12'hFFF;
                end
            end
            m_active = n_act;
            m_done   = n_done;
            for (int i = 0; i < NCH; i++) m_ptr[i] = n_ptr[i];
            m_play_d = bus.play;
            cyc++;
        end
        armed = 1'b1;
    end

    // ---------------- timing monitor with literal expectations ----------------
    int   rel, last_mv, mv_cyc;
    bit   seen_mv, prev_mv;
    int   done_cnt [NCH] = '{0, 0, 0, 0};
    int   done_cyc [NCH] = '{0, 0, 0, 0};

    // Track mix_valid width/spacing/first position and done pulse counts relative to reset release.
    always @(negedge clk) begin
        if (reset) begin
            rel = 0; seen_mv = 1'b0; prev_mv = 1'b0;
        end else begin
            if (bus.mix_valid === 1'b1) begin
                chk("mv_width", prev_mv, 0);
                if (!seen_mv) chk("first_mv_cycle", rel, 21);
                else          chk("mv_spacing", rel - last_mv, 16);
                seen_mv = 1'b1;
                last_mv = rel;
                mv_cyc  = rel;
            end
            prev_mv = (bus.mix_valid === 1'b1);
            for (int i = 0; i < NCH; i++) begin
                if (bus.done[i] === 1'b1) begin
                    done_cnt[i]++;
                    done_cyc[i] = rel;
                end
            end
            rel++;
        end
    end

    // ---------------- stimulus helpers ----------------
    int q[$];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input int st, input int en, input bit lp);
        bus.start_addr[ch*AW +: AW] = AW'(st);
        bus.end_addr[ch*AW +: AW]   = AW'(en);
        bus.loop[ch]                = lp;
    endtask

    task automatic pulse(input logic [3:0] mask);
        bus.play = mask;
        step(1);
        bus.play = '0;
    endtask

    // Wait (bounded) for the next mix_valid, return its mix, and realign to just after the next edge.
    task automatic next_mix(output logic [6:0] m);
        bit got;
        got = 1'b0;
        m   = '0;
        repeat (40) begin
            if (!got) begin
                @(negedge clk);
                if (bus.mix_valid === 1'b1) begin
                    got = 1'b1;
                    m   = bus.mix;
                end
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL mix_valid_timeout: got none expected one within 40 cycles at t=%0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic exp_seq(input string nm);
        logic [6:0] m;
        foreach (q[i]) begin
            next_mix(m);
            chk(nm, m, q[i]);
        end
    endtask

    // ---------------- directed scenarios then random soak ----------------
    initial begin
        logic [6:0] m;
        int d0, d1, k, st, en;
        reset          = 1'b1;
        bus.play       = 4'b0001;
        bus.stop       = '0;
        bus.loop       = '0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        step(3);
        reset = 1'b0;

        // play held high through reset release must not trigger
        step(30);
        chk("play_held_reset", bus.active, 0);
        bus.play = '0;

        // one-shot 10..13
        set_ch(0, 10, 13, 1'b0);
        next_mix(m);
        d0 = done_cnt[0];
        pulse(4'b0001);
        q = {10, 11, 12, 13, 0};
        exp_seq("oneshot_mix");
        chk("oneshot_done_cnt", done_cnt[0] - d0, 1);
        chk("oneshot_active", bus.active[0], 0);

        // loop 20..21, then stop
        set_ch(1, 20, 21, 1'b1);
        d1 = done_cnt[1];
        pulse(4'b0010);
        q = {20, 21, 20, 21};
        exp_seq("loop_mix");
        bus.stop = 4'b0010;
        step(2);
        chk("stop_active", bus.active[1], 0);
        q = {0};
        exp_seq("stop_mix");
        bus.stop = '0;
        chk("stop_no_done", done_cnt[1] - d1, 0);

        // full mix, all channels one sample of 31
        for (int i = 0; i < NCH; i++) set_ch(i, 31, 31, 1'b0);
        pulse(4'b1111);
        q = {124};
        exp_seq("full_mix");
        chk("full_done_to_mv", mv_cyc - done_cyc[0], 4);
        for (int i = 1; i < NCH; i++) chk("done_stagger", done_cyc[i] - done_cyc[0], i);
        q = {0};
        exp_seq("full_after");

        // retrigger 0..7 after three samples
        set_ch(0, 0, 7, 1'b0);
        d0 = done_cnt[0];
        pulse(4'b0001);
        q = {0, 1, 2};
        exp_seq("retrig_a");
        pulse(4'b0001);
        q = {0, 1, 2, 3, 4, 5, 6, 7, 0};
        exp_seq("retrig_b");
        chk("retrig_done_cnt", done_cnt[0] - d0, 1);

        // play edge with stop in the same cycle
        bus.play = 4'b0100;
        bus.stop = 4'b0100;
        step(1);
        bus.play = '0;
        bus.stop = '0;
        step(3);
        chk("play_stop_same", bus.active[2], 0);
        q = {0};
        exp_seq("play_stop_mix");

        // reset in the middle of a scan (tick+3)
        set_ch(0, 5, 9, 1'b1);
        pulse(4'b0001);
        q = {5};
        exp_seq("pre_reset_mix");
        step(12);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mix",       bus.mix,       0);
        chk("rst_mix_valid", bus.mix_valid, 0);
        chk("rst_active",    bus.active,    0);
        chk("rst_done",      bus.done,      0);
        chk("rst_rom_addr",  bus.rom_addr,  0);
        @(posedge clk);
        #1;
        q = {0};
        exp_seq("post_reset_mix");

        // random soak
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, NCH - 1);
                bus.play[k] = ~bus.play[k];
            end
            if ($urandom_range(0, 23) == 0) begin
                k = $urandom_range(0, NCH - 1);
                bus.stop[k] = ~bus.stop[k];
            end
            if ($urandom_range(0, 63) == 0) begin
                k = $urandom_range(0, NCH - 1);
                bus.loop[k] = ~bus.loop[k];
            end
            if ($urandom_range(0, 63) == 0) begin
                k  = $urandom_range(0, NCH - 1);
                st = $urandom_range(0, 40);
                en = st + $urandom_range(0, 8) - 2;
                if (en < 0) en = 0;
                set_ch(k, st, en, bus.loop[k]);
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                step(2);
                reset = 1'b0;
            end
            step(1);
        end

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
